// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_writeback_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests; exposes every slot's address and
// validity so the owner can do hazard lookups across queued entries.
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  wb_req_t               push_data_i,
    input  logic                  pop_i,
    output wb_req_t               head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CntW-1:0]       count_o,
    output logic [REG_ADDR_W-1:0] entry_addr_o [DEPTH],
    output logic [DEPTH-1:0]      valid_o
);

    wb_req_t         mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the occupancy count masks stale slots.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_comb begin
        logic [PtrW-1:0] offset;
        offset  = '0;
        valid_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_addr_o[i] = mem_q[i].addr;
            offset          = PtrW'(i) - rd_ptr_q;
            valid_o[i]      = (CntW'(offset) < count_q);
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-port arbiter: pipeline results win the slot, queued MDU results fill
// idle slots, and an age counter stalls the pipeline so the queue always drains.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_reg,
    input  logic [REG_DATA_W-1:0] pipe_data,
    output logic                  pipe_ready,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_reg,
    input  logic [REG_DATA_W-1:0] mdu_data,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] query_reg,
    output logic                  query_hit,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [REG_DATA_W-1:0] writeData,
    output logic                  enable
);

    localparam int unsigned AgeW = $clog2(MAX_WAIT + 1);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    wb_req_t               fifo_head;
    logic [REG_ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DEPTH-1:0]      fifo_valid;
    logic                  fifo_full, fifo_empty;
    logic [CntW-1:0]       fifo_count;
    logic                  fifo_push, fifo_pop, pipe_wr;

    logic [AgeW-1:0]       age_q, age_d;
    logic                  enable_q, enable_d;
    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [REG_DATA_W-1:0] write_data_q, write_data_d;

    assign pipe_ready = (age_q < AgeW'(MAX_WAIT));
    assign mdu_ready  = !fifo_full;
    assign pipe_wr    = pipe_valid && pipe_ready && (pipe_reg != REG_ZERO);
    assign fifo_pop   = !pipe_wr && !fifo_empty;
    assign fifo_push  = mdu_valid && mdu_ready && (mdu_reg != REG_ZERO);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (fifo_push),
        .push_data_i  ('{addr: mdu_reg, data: mdu_data}),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count),
        .entry_addr_o (fifo_addr),
        .valid_o      (fifo_valid)
    );

    always_comb begin
        age_d = age_q;
        if (fifo_pop || fifo_count == '0) begin
            age_d = '0;
        end else if (age_q != AgeW'(MAX_WAIT)) begin
            age_d = age_q + AgeW'(1);
        end
    end

    always_comb begin
        enable_d     = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (pipe_wr) begin
            enable_d     = 1'b1;
            write_reg_d  = pipe_reg;
            write_data_d = pipe_data;
        end else if (fifo_pop) begin
            enable_d     = 1'b1;
            write_reg_d  = fifo_head.addr;
            write_data_d = fifo_head.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q        <= '0;
            enable_q     <= 1'b0;
            write_reg_q  <= REG_ZERO;
            write_data_q <= '0;
        end else begin
            age_q        <= age_d;
            enable_q     <= enable_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    // Hazard lookup sees queued entries only, not the write on the output.
    always_comb begin
        query_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i] && fifo_addr[i] == query_reg) query_hit = 1'b1;
        end
        if (query_reg == REG_ZERO) query_hit = 1'b0;
    end

    assign enable    = enable_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a queue-based reference model.
module tb_regfile_writeback;
    import regfile_writeback_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MAX_WAIT = 4;

    logic        clk, rst;
    logic        pipe_valid, pipe_ready, mdu_valid, mdu_ready, query_hit, enable;
    logic [4:0]  pipe_reg, mdu_reg, query_reg, writeReg;
    logic [31:0] pipe_data, mdu_data, writeData;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_writeback #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_reg   (pipe_reg),
        .pipe_data  (pipe_data),
        .pipe_ready (pipe_ready),
        .mdu_valid  (mdu_valid),
        .mdu_reg    (mdu_reg),
        .mdu_data   (mdu_data),
        .mdu_ready  (mdu_ready),
        .query_reg  (query_reg),
        .query_hit  (query_hit),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .enable     (enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending MDU results and a wait counter.
    wb_req_t     mq[$];
    wb_req_t     m_head;
    int          m_age;
    int          m_pre;
    bit          m_popped;
    logic        exp_en;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_age    = 0;
            exp_en   = 1'b0;
            exp_reg  = 5'd0;
            exp_data = 32'd0;
        end else begin
            m_pre    = mq.size();
            m_popped = 1'b0;
            if (pipe_valid && m_age < MAX_WAIT && pipe_reg != 5'd0) begin
                exp_en   = 1'b1;
                exp_reg  = pipe_reg;
                exp_data = pipe_data;
            end else if (m_pre > 0) begin
                m_head   = mq.pop_front();
                exp_en   = 1'b1;
                exp_reg  = m_head.addr;
                exp_data = m_head.data;
                m_popped = 1'b1;
            end else begin
                exp_en = 1'b0;
            end
            if (mdu_valid && m_pre < DEPTH && mdu_reg != 5'd0)
                mq.push_back('{addr: mdu_reg, data: mdu_data});
            if (m_popped || m_pre == 0) m_age = 0;
            else if (m_age < MAX_WAIT) m_age++;
        end
    end

    function automatic bit model_hit(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].addr == r) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        check("enable", enable, exp_en);
        if (exp_en) begin
            check("writeReg", writeReg, exp_reg);
            check("writeData", writeData, exp_data);
        end
        check("pipe_ready", pipe_ready, (m_age < MAX_WAIT));
        check("mdu_ready", mdu_ready, (mq.size() < DEPTH));
        check("query_hit", query_hit, model_hit(query_reg));
        check("no_reg0_write", (enable && writeReg == 5'd0), 1'b0);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [4:0]  got[$];
    logic [31:0] got_d[$];
    int          idx;
    bit          acc;

    initial begin
        rst = 1'b1;
        pipe_valid = 1'b0; pipe_reg = 5'd0; pipe_data = 32'd0;
        mdu_valid  = 1'b0; mdu_reg  = 5'd0; mdu_data  = 32'd0;
        query_reg  = 5'd9;
        #8;
        check("rst_enable", enable, 1'b0);
        check("rst_writeReg", writeReg, 5'd0);
        check("rst_writeData", writeData, 32'd0);
        check("rst_pipe_ready", pipe_ready, 1'b1);
        check("rst_mdu_ready", mdu_ready, 1'b1);
        check("rst_query_hit", query_hit, 1'b0);
        #4 rst = 1'b0;

        // Single pipeline write.
        pipe_valid = 1'b1; pipe_reg = 5'd5; pipe_data = 32'h0000_00AA;
        step();
        pipe_valid = 1'b0;
        check("t1_enable", enable, 1'b1);
        check("t1_reg", writeReg, 5'd5);
        check("t1_data", writeData, 32'h0000_00AA);
        step();
        check("t1_idle", enable, 1'b0);

        // MDU result goes through the queue: written one edge after enqueue.
        mdu_valid = 1'b1; mdu_reg = 5'd9; mdu_data = 32'h1234_5678;
        step();
        mdu_valid = 1'b0;
        check("t2_no_bypass", enable, 1'b0);
        check("t2_hit", query_hit, 1'b1);
        step();
        check("t2_enable", enable, 1'b1);
        check("t2_reg", writeReg, 5'd9);
        check("t2_data", writeData, 32'h1234_5678);
        check("t2_hit_after", query_hit, 1'b0);

        // Saturated pipeline forces a single stall for the waiting MDU entry.
        pipe_valid = 1'b1; pipe_reg = 5'd3; pipe_data = 32'h33;
        mdu_valid = 1'b1; mdu_reg = 5'd7; mdu_data = 32'h77;
        step();
        mdu_valid = 1'b0;
        check("t3_first", writeReg, 5'd3);
        for (int i = 0; i < 4; i++) begin
            check("t3_ready", pipe_ready, 1'b1);
            step();
            check("t3_pipe_reg", writeReg, 5'd3);
        end
        check("t3_stall", pipe_ready, 1'b0);
        step();
        check("t3_mdu_reg", writeReg, 5'd7);
        check("t3_mdu_data", writeData, 32'h77);
        check("t3_resume", pipe_ready, 1'b1);
        step();
        check("t3_pipe_again", writeReg, 5'd3);

        // Three MDU results against a saturated pipeline; queue fills at two.
        idx = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (idx < 3) begin
                mdu_valid = 1'b1;
                mdu_reg   = 5'(10 + idx);
                mdu_data  = 32'hA000_0000 + 32'(idx);
            end else begin
                mdu_valid = 1'b0;
            end
            acc = mdu_valid && mdu_ready;
            if (cyc == 2) check("t4_full", mdu_ready, 1'b0);
            step();
            if (acc) idx++;
            if (enable && writeReg >= 5'd10 && writeReg <= 5'd12) begin
                got.push_back(writeReg);
                got_d.push_back(writeData);
            end
            if (got.size() == 3) break;
        end
        mdu_valid = 1'b0;
        check("t4_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            check("t4_order", got[i], 5'(10 + i));
            check("t4_data", got_d[i], 32'hA000_0000 + 32'(i));
        end
        pipe_valid = 1'b0;
        step();

        // Pipeline result to r0 yields its slot to the queued entry.
        mdu_valid = 1'b1; mdu_reg = 5'd4; mdu_data = 32'h4444;
        step();
        mdu_valid = 1'b0;
        pipe_valid = 1'b1; pipe_reg = 5'd0; pipe_data = 32'hDEAD;
        check("t5_ready", pipe_ready, 1'b1);
        step();
        pipe_valid = 1'b0;
        check("t5_enable", enable, 1'b1);
        check("t5_reg", writeReg, 5'd4);
        check("t5_data", writeData, 32'h4444);

        // MDU result to r0 is discarded.
        mdu_valid = 1'b1; mdu_reg = 5'd0; mdu_data = 32'hBAD0;
        step();
        mdu_valid = 1'b0;
        step();
        check("t5_r0_discard", enable, 1'b0);

        // Asynchronous reset with two entries queued and a write on the port.
        pipe_valid = 1'b1; pipe_reg = 5'd3; pipe_data = 32'h3333;
        mdu_valid = 1'b1; mdu_reg = 5'd20; mdu_data = 32'h2020;
        step();
        mdu_reg = 5'd21; mdu_data = 32'h2121;
        step();
        mdu_valid = 1'b0;
        query_reg = 5'd20;
        check("t6_pre_enable", enable, 1'b1);
        check("t6_pre_full", mdu_ready, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("t6_enable", enable, 1'b0);
        check("t6_reg", writeReg, 5'd0);
        check("t6_data", writeData, 32'd0);
        pipe_valid = 1'b0;
        #2 rst = 1'b0;
        step();
        check("t6_mdu_ready", mdu_ready, 1'b1);
        check("t6_query", query_hit, 1'b0);
        check("t6_no_write", enable, 1'b0);
        step();
        check("t6_no_write2", enable, 1'b0);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
